// File: rtl/fp_seq_pkg.sv
// Shared encodings and default latencies for the FP sequencer, FPU units and control decoder.
package fp_seq_pkg;

   // FP instruction classes as delivered by the control unit
   localparam logic [1:0] OP_SINGLE = 2'd0;
   localparam logic [1:0] OP_MUL    = 2'd1;
   localparam logic [1:0] OP_DIV    = 2'd2;
   localparam logic [1:0] OP_DMEM   = 2'd3;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StExec   = 2'd1,
      StDmemHi = 2'd2
   } fp_seq_state_e;

   // Total occupancy in cycles, including the acceptance cycle
   localparam int unsigned DEF_MUL_LAT   = 3;
   localparam int unsigned DEF_DIV_LAT_S = 12;
   localparam int unsigned DEF_DIV_LAT_D = 26;
   localparam int unsigned DEF_CNT_W     = 5;

   function automatic int unsigned lat_max(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   // Count up on inc, clear has priority, hold once saturated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fp_seq_ctrl.sv
// Multi-cycle sequencer for FP multiply/divide and double-word FP load/store.
// Outputs are decoded combinationally from the current state and inputs so a
// single-cycle op writes back in its issue cycle.
module fp_seq_ctrl
   import fp_seq_pkg::*;
#(
   parameter int unsigned MUL_LAT   = DEF_MUL_LAT,
   parameter int unsigned DIV_LAT_S = DEF_DIV_LAT_S,
   parameter int unsigned DIV_LAT_D = DEF_DIV_LAT_D,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   input  logic [1:0]  op_class,
   input  logic        is_double,
   input  logic        mem_write,
   input  logic        flush,
   output logic        pc_hold,
   output logic        fpu_start,
   output logic        word_sel,
   output logic        fp_reg_we,
   output logic        mem_en,
   output logic        busy,
   output logic [15:0] stall_cnt
);

   localparam int unsigned MaxLat = lat_max(MUL_LAT, DIV_LAT_S, DIV_LAT_D);

   if (MUL_LAT < 2 || DIV_LAT_S < 2 || DIV_LAT_D < 2) begin : g_bad_lat
      $fatal(1, "fp_seq_ctrl: every latency must be at least 2");
   end
   if (MaxLat > (2 ** CNT_W) + 1) begin : g_bad_cnt_w
      $fatal(1, "fp_seq_ctrl: CNT_W too narrow for the longest latency");
   end

   // The acceptance cycle and the write-back cycle are not counted down
   localparam logic [CNT_W-1:0] MulLoad  = CNT_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] DivSLoad = CNT_W'(DIV_LAT_S - 2);
   localparam logic [CNT_W-1:0] DivDLoad = CNT_W'(DIV_LAT_D - 2);

   fp_seq_state_e    state;
   logic [1:0]       op_r;
   logic             dbl_r;
   logic             wr_r;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   assign accept = (state == StIdle) && issue_valid && !flush;
   assign busy   = (state != StIdle);

   // Output decode from state, latched op info and live inputs
   always_comb begin
      pc_hold   = 1'b0;
      fpu_start = 1'b0;
      word_sel  = 1'b0;
      fp_reg_we = 1'b0;
      mem_en    = 1'b0;
      case (state)
         StIdle: begin
            if (accept) begin
               unique case (op_class)
                  OP_SINGLE: fp_reg_we = 1'b1;
                  OP_MUL, OP_DIV: begin
                     fpu_start = 1'b1;
                     pc_hold   = 1'b1;
                  end
                  OP_DMEM: begin
                     mem_en    = 1'b1;
                     pc_hold   = 1'b1;
                     fp_reg_we = ~mem_write;
                  end
               endcase
            end
         end
         StExec: begin
            if (!flush) begin
               if (cnt != '0) pc_hold = 1'b1;
               else           fp_reg_we = 1'b1;
            end
         end
         StDmemHi: begin
            word_sel = 1'b1;
            if (!flush) begin
               mem_en    = 1'b1;
               fp_reg_we = ~wr_r;
            end
         end
         default: ;
      endcase
   end

   // Sequencer state, latched instruction info and latency countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StIdle;
         op_r  <= OP_SINGLE;
         dbl_r <= 1'b0;
         wr_r  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (accept) begin
                  op_r  <= op_class;
                  dbl_r <= is_double;
                  wr_r  <= mem_write;
                  unique case (op_class)
                     OP_SINGLE: ;
                     OP_MUL: begin
                        cnt   <= MulLoad;
                        state <= StExec;
                     end
                     OP_DIV: begin
                        cnt   <= is_double ? DivDLoad : DivSLoad;
                        state <= StExec;
                     end
                     OP_DMEM: state <= StDmemHi;
                  endcase
               end
            end
            StExec: begin
               if (flush) begin
                  cnt   <= '0;
                  state <= StIdle;
               end else if (cnt == '0) begin
                  state <= StIdle;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StDmemHi: begin
               cnt   <= '0;
               state <= StIdle;
            end
            default: begin
               cnt   <= '0;
               state <= StIdle;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH(16)
   ) u_stall_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (1'b0),
      .inc  (pc_hold),
      .count(stall_cnt)
   );

   // The countdown never exceeds the load value of the op that started it
   a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (state == StExec) |-> ((op_r == OP_MUL) ? (cnt <= MulLoad) :
                             ((op_r == OP_DIV) && (cnt <= (dbl_r ? DivDLoad : DivSLoad)))));

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Self-checking bench for fp_seq_ctrl against a per-instruction cycle model.
module tb_fp_seq_ctrl;
   import fp_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic [1:0]  op_class = 2'd0;
   logic        is_double = 1'b0;
   logic        mem_write = 1'b0;
   logic        flush = 1'b0;
   logic        pc_hold, fpu_start, word_sel, fp_reg_we, mem_en, busy;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   fp_seq_ctrl #(
      .MUL_LAT  (3),
      .DIV_LAT_S(12),
      .DIV_LAT_D(26),
      .CNT_W    (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_valid(issue_valid),
      .op_class   (op_class),
      .is_double  (is_double),
      .mem_write  (mem_write),
      .flush      (flush),
      .pc_hold    (pc_hold),
      .fpu_start  (fpu_start),
      .word_sel   (word_sel),
      .fp_reg_we  (fp_reg_we),
      .mem_en     (mem_en),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          m_stall = 0;
   // {busy, fpu_start, pc_hold, word_sel, fp_reg_we, mem_en}
   logic [5:0]  obs;
   logic [15:0] obs_cnt;
   logic [5:0]  exp_q[$];

   function automatic int lat_of(input logic [1:0] op, input logic dbl);
      if (op == OP_MUL) return 3;
      if (op == OP_DIV) return dbl ? 26 : 12;
      if (op == OP_DMEM) return 2;
      return 1;
   endfunction

   // Expected output vector of every cycle the instruction occupies
   task automatic build_exp(input logic [1:0] op, input logic dbl, input logic wr);
      int l;
      exp_q.delete();
      if (op == OP_SINGLE) begin
         exp_q.push_back(6'b000010);
      end else if (op == OP_DMEM) begin
         exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, ~wr, 1'b1});
         exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, ~wr, 1'b1});
      end else begin
         l = lat_of(op, dbl);
         for (int i = 0; i < l; i++)
            exp_q.push_back({(i > 0), (i == 0), (i < l - 1), 1'b0, (i == l - 1), 1'b0});
      end
   endtask

   function automatic void bump_stall();
      m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
   endfunction

   task automatic drive(input logic iv, input logic [1:0] op, input logic dbl, input logic wr,
                        input logic fl);
      @(negedge clk);
      issue_valid = iv;
      op_class    = op;
      is_double   = dbl;
      mem_write   = wr;
      flush       = fl;
      #1;
      obs     = {busy, fpu_start, pc_hold, word_sel, fp_reg_we, mem_en};
      obs_cnt = stall_cnt;
   endtask

   task automatic drive_noise();
      drive(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
   endtask

   // Issue one instruction and check every cycle it occupies; noise on inputs afterwards
   task automatic seq_instr(input string tag, input logic [1:0] op, input logic dbl,
                            input logic wr, output int we_seen);
      build_exp(op, dbl, wr);
      we_seen = 0;
      foreach (exp_q[i]) begin
         if (i == 0) drive(1'b1, op, dbl, wr, 1'b0);
         else        drive_noise();
         we_seen += int'(obs[1]);
         n_checks++;
         if (obs !== exp_q[i]) begin
            n_errors++;
            $display("FAIL %s cyc%0d outs got=%b want=%b", tag, i, obs, exp_q[i]);
         end
         n_checks++;
         if (obs_cnt !== 16'(m_stall)) begin
            n_errors++;
            $display("FAIL %s cyc%0d stall_cnt got=%0d want=%0d", tag, i, obs_cnt, m_stall);
         end
         if (exp_q[i][3]) bump_stall();
      end
   endtask

   task automatic test_reset();
      int we;
      @(negedge clk);
      #1;
      n_checks++;
      if ({busy, fpu_start, pc_hold, word_sel, fp_reg_we, mem_en, stall_cnt} !== 22'd0) begin
         n_errors++;
         $display("FAIL reset_idle got=%b/%0d want=0/0",
                  {busy, fpu_start, pc_hold, word_sel, fp_reg_we, mem_en}, stall_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0);
      drive(1'b0, OP_SINGLE, 1'b0, 1'b0, 1'b0);
      drive(1'b0, OP_SINGLE, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, fpu_start, pc_hold, word_sel, fp_reg_we, mem_en, stall_cnt} !== 22'd0) begin
         n_errors++;
         $display("FAIL reset_mid_exec got=%b/%0d want=0/0",
                  {busy, fpu_start, pc_hold, word_sel, fp_reg_we, mem_en}, stall_cnt);
      end
      drive(1'b0, OP_SINGLE, 1'b0, 1'b0, 1'b0);
      rst_n   = 1'b1;
      m_stall = 0;
      seq_instr("single", OP_SINGLE, 1'b0, 1'b0, we);
      drive(1'b0, OP_SINGLE, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== 6'b000000) begin
         n_errors++;
         $display("FAIL single_after got=%b want=000000", obs);
      end
   endtask

   task automatic test_mul();
      int we;
      int start;
      start = m_stall;
      seq_instr("mul", OP_MUL, 1'($urandom), 1'($urandom), we);
      n_checks++;
      if (we != 1) begin
         n_errors++;
         $display("FAIL mul_we_count got=%0d want=1", we);
      end
      drive(1'b0, OP_MUL, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs_cnt !== 16'(start + 2)) begin
         n_errors++;
         $display("FAIL mul_stall got=%0d want=%0d", obs_cnt, start + 2);
      end
   endtask

   task automatic test_div();
      int we;
      seq_instr("div_s", OP_DIV, 1'b0, 1'($urandom), we);
      n_checks++;
      if (we != 1) begin
         n_errors++;
         $display("FAIL div_s_we_count got=%0d want=1", we);
      end
      seq_instr("div_d", OP_DIV, 1'b1, 1'($urandom), we);
      n_checks++;
      if (we != 1) begin
         n_errors++;
         $display("FAIL div_d_we_count got=%0d want=1", we);
      end
   endtask

   task automatic test_back_to_back();
      int we;
      seq_instr("ldc1", OP_DMEM, 1'($urandom), 1'b0, we);
      seq_instr("sdc1", OP_DMEM, 1'($urandom), 1'b1, we);
      drive(1'b0, OP_DMEM, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== 6'b000000) begin
         n_errors++;
         $display("FAIL dmem_after got=%b want=000000", obs);
      end
   endtask

   task automatic test_flush();
      int we;
      build_exp(OP_DIV, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b1, OP_DIV, 1'b1, 1'b0, 1'b0);
         else        drive_noise();
         n_checks++;
         if (obs !== exp_q[i]) begin
            n_errors++;
            $display("FAIL flush_pre cyc%0d got=%b want=%b", i, obs, exp_q[i]);
         end
         if (exp_q[i][3]) bump_stall();
      end
      drive(1'b1, OP_MUL, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs !== 6'b100000) begin
         n_errors++;
         $display("FAIL flush_exec got=%b want=100000", obs);
      end
      drive(1'b0, OP_MUL, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== 6'b000000) begin
         n_errors++;
         $display("FAIL flush_idle got=%b want=000000", obs);
      end
      seq_instr("flush_mul", OP_MUL, 1'b0, 1'b0, we);
      // Flush in DMEM_HI suppresses the high-word access
      drive(1'b1, OP_DMEM, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== 6'b001011) begin
         n_errors++;
         $display("FAIL flush_ld_lo got=%b want=001011", obs);
      end
      bump_stall();
      drive(1'b1, OP_SINGLE, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ((obs & 6'b111011) !== 6'b100000) begin
         n_errors++;
         $display("FAIL flush_ld_hi got=%b want=100x00", obs);
      end
      // Flush in IDLE blocks acceptance
      drive(1'b1, OP_MUL, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs !== 6'b000000) begin
         n_errors++;
         $display("FAIL flush_in_idle got=%b want=000000", obs);
      end
      drive(1'b0, OP_MUL, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ((obs !== 6'b000000) || (obs_cnt !== 16'(m_stall))) begin
         n_errors++;
         $display("FAIL flush_idle_after got=%b/%0d want=000000/%0d", obs, obs_cnt, m_stall);
      end
   endtask

   task automatic test_random();
      int we;
      logic [1:0] op;
      for (int n = 0; n < 30; n++) begin
         op = 2'($urandom);
         seq_instr("rand", op, 1'($urandom), 1'($urandom), we);
         n_checks++;
         if (we != ((op == OP_DMEM) ? 2 - int'(exp_q[0][1] == 1'b0) * 2 : 1)) begin
            n_errors++;
            $display("FAIL rand_we_count op=%0d got=%0d", op, we);
         end
         if ($urandom_range(0, 2) == 0) begin
            drive(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            n_checks++;
            if (obs !== 6'b000000) begin
               n_errors++;
               $display("FAIL rand_gap got=%b want=000000", obs);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int we;
      @(negedge clk);
      issue_valid = 1'b0;
      flush       = 1'b0;
      force dut.u_stall_cnt.count_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.u_stall_cnt.count_q;
      m_stall = 65534;
      seq_instr("sat_div_d", OP_DIV, 1'b1, 1'b0, we);
      drive(1'b0, OP_SINGLE, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs_cnt !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL sat_hold got=%h want=ffff", obs_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_back_to_back();
      test_flush();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fp_seq_ctrl.md
Name: fp_seq_ctrl

Overview:
- Multi-cycle sequencer for the FPU datapath and the double-word FP load/store path of the MIPS core.
- Decodes-in: an FP instruction class from the control unit.
- Drives out: the PC hold, FPU start pulse, half-word select (low/high register and +0/+4 address), FP register write enable and memory enable.
- Lets the existing combinational ALU_fp be replaced by multi-cycle multiply/divide units without changing the top-level PC logic.

Parameters:
- MUL_LAT, 3: total cycles occupied by mul.s/mul.d; must be >=2.
- DIV_LAT_S, 12: total cycles for div.s; must be >=2.
- DIV_LAT_D, 26: total cycles for div.d; must be >=2.
- CNT_W, 5: latency counter width; 2^CNT_W must be >= max(latency)-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  current IR is an FP instruction needing sequencing
- op_class  in  2  0 SINGLE, 1 MUL, 2 DIV, 3 DMEM (ldc1/sdc1)
- is_double  in  1  fmt bit; selects DIV_LAT_D over DIV_LAT_S
- mem_write  in  1  DMEM only: 1 store, 0 load
- flush  in  1  synchronous abort of the sequence in progress
- pc_hold  out  1  PC must not advance at the end of this cycle
- fpu_start  out  1  one-cycle start pulse to the multi-cycle FPU
- word_sel  out  1  0 low word (rt, addr+0), 1 high word (rt+1, addr+4)
- fp_reg_we  out  1  FP register file write enable
- mem_en  out  1  data-memory access this cycle
- busy  out  1  state != IDLE
- stall_cnt  out  16  saturating count of cycles with pc_hold=1

Behaviour:
- States are IDLE, EXEC and DMEM_HI. Latched at acceptance: op_r, dbl_r, wr_r and cnt[CNT_W-1:0].
- Reset (async, rst_n=0) sets state=IDLE, cnt=0, op_r/dbl_r/wr_r=0 and stall_cnt=0.
  - Outputs are combinational from state and inputs, so all are 0 whenever in IDLE with issue_valid=0.
  - Reset mid-sequence abandons it with no further writes.
- Acceptance occurs only in IDLE with issue_valid=1 and flush=0. issue_valid is ignored outside IDLE.
- IDLE, SINGLE: fp_reg_we=1 and pc_hold=0 in the same cycle; stay in IDLE. This is 1-cycle latency.
- IDLE, MUL/DIV:
  - Outputs: fpu_start=1, pc_hold=1.
  - Load cnt with L-2, where L is MUL_LAT, or DIV_LAT_S/DIV_LAT_D chosen by is_double. Go to EXEC.
- EXEC:
  - cnt!=0: pc_hold=1, cnt decrements.
  - cnt==0: fp_reg_we=1, pc_hold=0; go to IDLE.
  - The instruction occupies exactly L cycles; fp_reg_we is high only in the last one.
- IDLE, DMEM:
  - Outputs: word_sel=0, mem_en=1, pc_hold=1, fp_reg_we=~mem_write. Go to DMEM_HI.
- DMEM_HI:
  - Outputs: word_sel=1, mem_en=1, pc_hold=0, fp_reg_we=~wr_r. Go to IDLE.
- Back-to-back: a new instruction can be accepted in the cycle after any return to IDLE, with no bubble beyond that.
- flush=1 in EXEC or DMEM_HI:
  - That cycle forces fp_reg_we=0, mem_en=0, pc_hold=0.
  - Next state is IDLE and cnt clears.
  - flush=1 in IDLE blocks acceptance and all outputs stay 0.
- fpu_start is asserted only in the acceptance cycle, never in EXEC.
- stall_cnt increments on each cycle with pc_hold=1 and holds at 0xFFFF.
- Illegal parameter values (latency <2, or counter overflow) are caught by an elaboration-time check that produces a fatal error.

Decomposition:
- Shared package fp_seq_pkg:
  - op-class encoding (OP_SINGLE=0, OP_MUL=1, OP_DIV=2, OP_DMEM=3)
  - state encoding
  - default latency constants, reused by the FPU units and the control decoder
- One natural sub-module: sat_counter (width parameter, inc, sync clear, saturate at all-ones), used for stall_cnt.

Test Plan:
- Reset and SINGLE:
  - Stimulus: assert rst_n=0 mid-EXEC, release, then issue SINGLE.
  - Required: all outputs 0 during reset; fp_reg_we=1 and pc_hold=0 in the issue cycle; busy stays 0.
- MUL timing:
  - Stimulus: issue MUL with MUL_LAT=3.
  - Required: fpu_start=1 only in cycle 0; pc_hold=1,1,0 over cycles 0-2; fp_reg_we=1 only in cycle 2; stall_cnt=2.
- DIV single vs double:
  - Stimulus: issue DIV with is_double=0, then DIV with is_double=1.
  - Required: 12 and 26 total cycles respectively, each with exactly one fp_reg_we.
- ldc1 then sdc1 back-to-back:
  - Required for load: word_sel=0,1, mem_en=1,1, fp_reg_we=1,1.
  - Required for store: word_sel=0,1, mem_en=1,1, fp_reg_we=0,0.
  - Store is accepted in the cycle immediately after the load's DMEM_HI.
- Flush:
  - Stimulus: flush=1 in the 5th cycle of div.d.
  - Required: no fp_reg_we, pc_hold=0 that cycle, IDLE next cycle, a new MUL accepted the following cycle.
- Saturation:
  - Stimulus: force stall_cnt near 0xFFFE and issue a div.d.
  - Required: stall_cnt reaches 0xFFFF and holds.
